// File: rtl/phase_scan_ctrl.sv
// phase_scan_ctrl: receive-side phase sequencer for one I or Q branch.
// The block steps through every downsampler sampling phase. At each phase it
// discards a settling period, then counts symbol errors over a fixed window.
// It then locks onto the phase with the fewest errors and enables the BER
// checker there.
// Optional feature: define PHASE_SCAN_CONT_TRACK_EN to keep monitoring errors
// while locked, and to rescan automatically when a window exceeds TRACK_THR.
module phase_scan_ctrl #(
  parameter int NB_PHASE   = 2,
  parameter int N_PHASES   = 4,
  parameter int NB_WIN     = 10,
  parameter int WIN_LEN    = 1023,
  parameter int SETTLE_LEN = 16,
  parameter int NB_ERR     = 10,
  parameter int TRACK_THR  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic                i_err,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_enb_rx,
  output logic                o_clr_ber,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_PHASE-1:0] o_best_phase,
  output logic [NB_ERR-1:0]   o_best_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    COMPARE = 3'd3,
    LOCK    = 3'd4
  } state_t;

  localparam logic [NB_WIN-1:0]   SETTLE_LAST = NB_WIN'(SETTLE_LEN - 1);
  localparam logic [NB_WIN-1:0]   WIN_LAST    = NB_WIN'(WIN_LEN - 1);
  localparam logic [NB_PHASE-1:0] PHASE_LAST  = NB_PHASE'(N_PHASES - 1);
  localparam logic [NB_ERR-1:0]   ERR_MAX     = {NB_ERR{1'b1}};
  localparam logic [NB_ERR-1:0]   TRACK_LIM   = NB_ERR'(TRACK_THR);

  state_t              state_q, state_d;
  logic [NB_PHASE-1:0] cur_phase_q, cur_phase_d;
  logic [NB_PHASE-1:0] best_phase_q, best_phase_d;
  logic [NB_ERR-1:0]   best_err_q, best_err_d;
  logic [NB_WIN-1:0]   sym_cnt_q, sym_cnt_d;
  logic [NB_ERR-1:0]   err_acc_q, err_acc_d;
  logic [NB_ERR-1:0]   acc_sat;
  logic                start_scan;

  logic [NB_PHASE-1:0] phase_d;
  logic                enb_rx_d;
  logic                clr_ber_d;
  logic                busy_d;
  logic                done_d;
  logic [NB_PHASE-1:0] best_phase_out_d;
  logic [NB_ERR-1:0]   best_err_out_d;

`ifndef PHASE_SCAN_CONT_TRACK_EN
  // Without tracking, LOCK never compares against the threshold.
  logic [NB_ERR-1:0] unused_track_lim;
  assign unused_track_lim = TRACK_LIM;
`endif

  // Error accumulator value after this strobe. It sticks at all-ones
  // instead of wrapping, so a very bad phase never looks like a good one.
  always_comb begin
    acc_sat = err_acc_q;
    if (i_err && (err_acc_q != ERR_MAX)) begin
      acc_sat = err_acc_q + NB_ERR'(1);
    end
  end

  // Next-state logic for the scan sequencer, plus the datapath updates.
  // A scan can start in two ways: from IDLE, or by a restart from LOCK.
  // Either way it resets the running best and raises a BER clear pulse.
  always_comb begin
    state_d          = state_q;
    cur_phase_d      = cur_phase_q;
    best_phase_d     = best_phase_q;
    best_err_d       = best_err_q;
    sym_cnt_d        = sym_cnt_q;
    err_acc_d        = err_acc_q;
    best_phase_out_d = o_best_phase;
    best_err_out_d   = o_best_err;
    clr_ber_d        = 1'b0;
    start_scan       = 1'b0;

    case (state_q)
      IDLE: begin
        start_scan = i_start;
      end

      SETTLE: begin
        if (i_valid) begin
          if (sym_cnt_q == SETTLE_LAST) begin
            sym_cnt_d = '0;
            err_acc_d = '0;
            state_d   = MEASURE;
          end else begin
            sym_cnt_d = sym_cnt_q + NB_WIN'(1);
          end
        end
      end

      MEASURE: begin
        if (i_valid) begin
          err_acc_d = acc_sat;
          if (sym_cnt_q == WIN_LAST) begin
            sym_cnt_d = '0;
            state_d   = COMPARE;
          end else begin
            sym_cnt_d = sym_cnt_q + NB_WIN'(1);
          end
        end
      end

      COMPARE: begin
        if (err_acc_q < best_err_q) begin
          best_err_d   = err_acc_q;
          best_phase_d = cur_phase_q;
        end
        sym_cnt_d = '0;
        clr_ber_d = 1'b1;
        if (cur_phase_q == PHASE_LAST) begin
          err_acc_d        = '0;
          best_phase_out_d = best_phase_d;
          best_err_out_d   = best_err_d;
          state_d          = LOCK;
        end else begin
          cur_phase_d = cur_phase_q + NB_PHASE'(1);
          state_d     = SETTLE;
        end
      end

      LOCK: begin
        if (i_start) begin
          start_scan = 1'b1;
        end
`ifdef PHASE_SCAN_CONT_TRACK_EN
        else if (i_valid) begin
          if (sym_cnt_q == WIN_LAST) begin
            if (acc_sat > TRACK_LIM) begin
              start_scan = 1'b1;
            end else begin
              sym_cnt_d = '0;
              err_acc_d = '0;
            end
          end else begin
            sym_cnt_d = sym_cnt_q + NB_WIN'(1);
            err_acc_d = acc_sat;
          end
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_scan) begin
      state_d      = SETTLE;
      cur_phase_d  = '0;
      best_phase_d = '0;
      best_err_d   = ERR_MAX;
      sym_cnt_d    = '0;
      err_acc_d    = '0;
      clr_ber_d    = 1'b1;
    end
  end

  // Output values are decoded from the next state, so every output is
  // registered. The phase selector only moves when the state changes.
  always_comb begin
    busy_d   = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == COMPARE);
    done_d   = (state_d == LOCK);
    enb_rx_d = (state_d != IDLE);
    phase_d  = '0;
    if (state_d == LOCK) begin
      phase_d = best_phase_d;
    end else if (state_d != IDLE) begin
      phase_d = cur_phase_d;
    end
  end

  // State, datapath and output registers, with a synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_phase_q  <= '0;
      best_phase_q <= '0;
      best_err_q   <= ERR_MAX;
      sym_cnt_q    <= '0;
      err_acc_q    <= '0;
      o_phase      <= '0;
      o_enb_rx     <= 1'b0;
      o_clr_ber    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_best_phase <= '0;
      o_best_err   <= ERR_MAX;
    end else begin
      state_q      <= state_d;
      cur_phase_q  <= cur_phase_d;
      best_phase_q <= best_phase_d;
      best_err_q   <= best_err_d;
      sym_cnt_q    <= sym_cnt_d;
      err_acc_q    <= err_acc_d;
      o_phase      <= phase_d;
      o_enb_rx     <= enb_rx_d;
      o_clr_ber    <= clr_ber_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_best_phase <= best_phase_out_d;
      o_best_err   <= best_err_out_d;
    end
  end

endmodule
